// File: rtl/sob_eob_recorder.sv
// SOB/EOB burst recorder: tracks burst state, counts triggers per burst and
// queues SOB/EOB records in a small FIFO drained over a valid/ready handshake.
module sob_eob_recorder #(
    parameter int FIFO_DEPTH = 4,
    parameter int BID_W      = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ECRST,
    input  logic        BCRST,
    input  logic        TRIGGER,
    input  logic        REC_READY,
    output logic        REC_VALID,
    output logic [63:0] REC_DATA,
    output logic [31:0] TIMESTAMP,
    output logic        IN_BURST,
    output logic        ERR_OVF,
    output logic        ERR_SEQ
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_r;
    logic [15:0]       trig_cnt_r;
    logic [BID_W-1:0]  bid_r;
    logic [63:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    logic              sob_s;
    logic              eob_s;
    logic              ill_s;
    logic              in_burst_s;
    logic [15:0]       trig_next_s;
    logic [13:0]       bid14_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              accept_s;
    logic              drop_s;
    logic              seq_err_s;
    logic [63:0]       rec_s;
    logic [CW-1:0]     count_next_s;

    // Event decode, record formation and FIFO push/pop qualification
    always_comb begin
        sob_s      = ECRST & BCRST;
        eob_s      = ECRST & ~BCRST;
        ill_s      = BCRST & ~ECRST;
        in_burst_s = (state_r == BURST);
        bid14_s    = 14'(bid_r);
        trig_next_s = trig_cnt_r;
        if (in_burst_s && TRIGGER && (trig_cnt_r != 16'hFFFF)) begin
            trig_next_s = trig_cnt_r + 16'd1;
        end else begin
            trig_next_s = trig_cnt_r;
        end
        // The EOB record already includes a trigger arriving in the EOB cycle
        rec_s = 64'd0;
        if (sob_s) begin
            rec_s = {2'b01, bid14_s, 16'd0, 32'd0};
        end else begin
            rec_s = {2'b10, bid14_s, trig_next_s, TIMESTAMP};
        end
        push_s    = sob_s | (eob_s & in_burst_s);
        pop_s     = REC_VALID & REC_READY;
        full_s    = (count_r == CW'(FIFO_DEPTH));
        accept_s  = push_s & (~full_s | pop_s);
        drop_s    = push_s & full_s & ~pop_s;
        seq_err_s = ill_s | (sob_s & in_burst_s) | (eob_s & ~in_burst_s);
        count_next_s = count_r;
        if (accept_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!accept_s && pop_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Burst state machine, timestamp, trigger count, burst ID and sequence error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            IN_BURST   <= 1'b0;
            TIMESTAMP  <= 32'd0;
            trig_cnt_r <= 16'd0;
            bid_r      <= '0;
            ERR_SEQ    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sob_s) begin
                        state_r  <= BURST;
                        IN_BURST <= 1'b1;
                    end
                end
                BURST: begin
                    if (eob_s) begin
                        state_r  <= IDLE;
                        IN_BURST <= 1'b0;
                        bid_r    <= bid_r + BID_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    IN_BURST <= 1'b0;
                end
            endcase
            TIMESTAMP  <= sob_s ? 32'd0 : (TIMESTAMP + 32'd1);
            trig_cnt_r <= sob_s ? 16'd0 : trig_next_s;
            ERR_SEQ    <= ERR_SEQ | seq_err_s;
        end
    end

    // Record storage; contents only matter between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= rec_s;
        end
    end

    // FIFO pointers, registered head-of-queue output and overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            REC_VALID <= 1'b0;
            REC_DATA  <= 64'd0;
            ERR_OVF   <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                if (count_r > CW'(1)) begin
                    REC_DATA <= mem_r[rd_ptr_r + AW'(1)];
                end else if (accept_s) begin
                    REC_DATA <= rec_s;
                end
            end else if ((count_r == CW'(0)) && accept_s) begin
                REC_DATA <= rec_s;
            end
            count_r   <= count_next_s;
            REC_VALID <= (count_next_s != CW'(0));
            ERR_OVF   <= ERR_OVF | drop_s;
        end
    end

endmodule
